// File: rtl/ara_xlat_client.sv
// ara_xlat_client: VLSU address translation client with local alignment check and a one-entry 4 KiB page cache.
// exception_t is packed as {cause[63:0], tval[63:0], valid} (129 bits), valid in bit 0.
module ara_xlat_client #(
  parameter int unsigned VLEN = 64,
  parameter int unsigned PLEN = 56
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [VLEN-1:0]  req_vaddr_i,
  input  logic             req_is_store_i,
  input  logic [1:0]       req_size_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [PLEN-1:0]  rsp_paddr_o,
  output logic [128:0]     rsp_exception_o,
  output logic             mmu_req_o,
  output logic [VLEN-1:0]  mmu_vaddr_o,
  output logic             mmu_is_store_o,
  output logic [128:0]     mmu_misaligned_ex_o,
  input  logic             mmu_valid_i,
  input  logic [PLEN-1:0]  mmu_paddr_i,
  input  logic [128:0]     mmu_exception_i
);
  typedef enum logic [1:0] {IDLE, MMU_WAIT, RESP} state_e;
  state_e state_q, state_d;
  logic [VLEN-1:0] vaddr_q;
  logic is_store_q, valid_q, st_ok_q, kill_q;
  logic [PLEN-1:0] paddr_q;
  logic [128:0] ex_q;
  logic [VLEN-13:0] tag_q;
  logic [PLEN-13:0] ppn_q;
  logic [2:0] mask;
  logic misaligned, hit, accept, done, fill;
  always_comb begin
    mask = {req_size_i == 2'd3, req_size_i[1], |req_size_i};
    misaligned = |(req_vaddr_i[2:0] & mask);
    hit = valid_q && !flush_i && tag_q == req_vaddr_i[VLEN-1:12] && (st_ok_q || !req_is_store_i);
    accept = state_q == IDLE && req_valid_i;
    done = state_q == MMU_WAIT && mmu_valid_i;
    fill = done && !mmu_exception_i[0] && !kill_q && !flush_i;
    req_ready_o = state_q == IDLE;
    rsp_valid_o = state_q == RESP;
    mmu_req_o = state_q == MMU_WAIT;
    state_d = state_q;
    if (accept) state_d = (misaligned || hit) ? RESP : MMU_WAIT;
    if (done) state_d = RESP;
    if (rsp_valid_o && rsp_ready_i) state_d = IDLE;
  end
  assign rsp_paddr_o = paddr_q;
  assign rsp_exception_o = ex_q;
  assign mmu_vaddr_o = vaddr_q;
  assign mmu_is_store_o = is_store_q;
  assign mmu_misaligned_ex_o = '0;
  always_ff @(posedge clk_i) state_q <= rst_i ? IDLE : state_d;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vaddr_q <= '0;
      is_store_q <= 1'b0;
      paddr_q <= '0;
      ex_q <= '0;
      tag_q <= '0;
      ppn_q <= '0;
      valid_q <= 1'b0;
      st_ok_q <= 1'b0;
      kill_q <= 1'b0;
    end else begin
      if (accept) begin
        vaddr_q <= req_vaddr_i;
        is_store_q <= req_is_store_i;
        if (misaligned) begin
          paddr_q <= '0;
          ex_q <= {64'(req_is_store_i ? 3'd6 : 3'd4), 64'(req_vaddr_i), 1'b1};
        end else if (hit) begin
          paddr_q <= {ppn_q, req_vaddr_i[11:0]};
          ex_q <= '0;
        end
      end
      if (done) begin
        paddr_q <= mmu_paddr_i;
        ex_q <= mmu_exception_i;
      end
      // store permission accumulates only while the same page stays cached
      if (fill) begin
        tag_q <= vaddr_q[VLEN-1:12];
        ppn_q <= mmu_paddr_i[PLEN-1:12];
        st_ok_q <= is_store_q | (valid_q && st_ok_q && tag_q == vaddr_q[VLEN-1:12]);
      end
      valid_q <= !flush_i && (valid_q || fill);
      kill_q <= state_d == MMU_WAIT && (kill_q || (state_q == MMU_WAIT && flush_i));
    end
  end
endmodule

// File: tb/tb_ara_xlat_client.sv
// tb_ara_xlat_client: table-driven directed checks of translation, page cache, alignment, flush and reset.
module tb_ara_xlat_client;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic req_valid = 1'b0, req_ready, req_st = 1'b0;
  logic [63:0] req_va = '0;
  logic [1:0] req_sz = '0;
  logic rsp_valid, rsp_ready = 1'b0;
  logic [55:0] rsp_paddr;
  logic [128:0] rsp_ex, mis_ex;
  logic mmu_req, mmu_st, mmu_valid = 1'b0;
  logic [63:0] mmu_va;
  logic [55:0] mmu_pa = '0;
  logic [128:0] mmu_ex = '0;
  int checks = 0, errors = 0;

  ara_xlat_client dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_vaddr_i(req_va),
    .req_is_store_i(req_st), .req_size_i(req_sz),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_paddr_o(rsp_paddr),
    .rsp_exception_o(rsp_ex),
    .mmu_req_o(mmu_req), .mmu_vaddr_o(mmu_va), .mmu_is_store_o(mmu_st),
    .mmu_misaligned_ex_o(mis_ex),
    .mmu_valid_i(mmu_valid), .mmu_paddr_i(mmu_pa), .mmu_exception_i(mmu_ex)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] va; logic st; logic [1:0] sz; logic fa; logic fw;
    int lat; logic [55:0] mp; logic [128:0] mx; int stall;
    int em; logic [55:0] ep; logic [128:0] ee;
  } vec_t;
  vec_t tv[15];

  function automatic logic [128:0] ex(input logic [63:0] c, input logic [63:0] t);
    return {c, t, 1'b1};
  endfunction

  task automatic chk(input string n, input logic [191:0] a, input logic [191:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask

  task automatic do_req(input int id, input vec_t v);
    int seen = 0, cyc = 0;
    @(negedge clk);
    chk($sformatf("v%0d ready", id), 192'(req_ready), 192'(1));
    req_valid = 1'b1; req_va = v.va; req_st = v.st; req_sz = v.sz; flush = v.fa;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    while (!rsp_valid && cyc < 50) begin
      if (mmu_req) begin
        seen++;
        chk($sformatf("v%0d mmu_vaddr", id), 192'({mmu_st, mmu_va}), 192'({v.st, v.va}));
        if (v.fw && seen == 1) flush = 1'b1;
        if (seen == v.lat) begin
          mmu_valid = 1'b1; mmu_pa = v.mp; mmu_ex = v.mx;
        end
      end
      @(posedge clk); #1;
      mmu_valid = 1'b0; flush = 1'b0; cyc++;
    end
    chk($sformatf("v%0d rsp_valid", id), 192'(rsp_valid), 192'(1));
    chk($sformatf("v%0d mmu_cycles", id), 192'(seen), 192'(v.em));
    chk($sformatf("v%0d latency", id), 192'(cyc), 192'(v.em));
    for (int i = 0; i < v.stall; i++) begin
      chk($sformatf("v%0d stall%0d", id, i), 192'({rsp_valid, mmu_req, rsp_paddr}), 192'({2'b10, v.ep}));
      @(posedge clk); #1;
    end
    chk($sformatf("v%0d paddr", id), 192'(rsp_paddr), 192'(v.ep));
    chk($sformatf("v%0d exception", id), 192'(rsp_ex), 192'(v.ee));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk($sformatf("v%0d idle", id), 192'({rsp_valid, req_ready}), 192'(2'b01));
  endtask

  initial begin
    tv[0]  = '{64'h8000_1008, 1'b0, 2'd3, 1'b0, 1'b0, 3, 56'h8_0000_5008, 129'd0, 0, 3, 56'h8_0000_5008, 129'd0};
    tv[1]  = '{64'h8000_1FF0, 1'b0, 2'd2, 1'b0, 1'b0, 0, 56'd0, 129'd0, 0, 0, 56'h8_0000_5FF0, 129'd0};
    tv[2]  = '{64'h8000_1010, 1'b1, 2'd3, 1'b0, 1'b0, 1, 56'h8_0000_5010, 129'd0, 0, 1, 56'h8_0000_5010, 129'd0};
    tv[3]  = '{64'h8000_1020, 1'b1, 2'd3, 1'b0, 1'b0, 0, 56'd0, 129'd0, 0, 0, 56'h8_0000_5020, 129'd0};
    tv[4]  = '{64'h8000_1002, 1'b1, 2'd2, 1'b0, 1'b0, 0, 56'd0, 129'd0, 0, 0, 56'd0, ex(64'd6, 64'h8000_1002)};
    tv[5]  = '{64'h8000_1001, 1'b0, 2'd0, 1'b0, 1'b0, 0, 56'd0, 129'd0, 0, 0, 56'h8_0000_5001, 129'd0};
    tv[6]  = '{64'h8000_1003, 1'b0, 2'd1, 1'b0, 1'b0, 0, 56'd0, 129'd0, 0, 0, 56'd0, ex(64'd4, 64'h8000_1003)};
    tv[7]  = '{64'h9000_0000, 1'b0, 2'd3, 1'b0, 1'b0, 2, 56'd0, ex(64'd13, 64'h9000_0000), 0, 2, 56'd0, ex(64'd13, 64'h9000_0000)};
    tv[8]  = '{64'h9000_0000, 1'b0, 2'd3, 1'b0, 1'b0, 1, 56'd0, ex(64'd13, 64'h9000_0000), 0, 1, 56'd0, ex(64'd13, 64'h9000_0000)};
    tv[9]  = '{64'h8000_1100, 1'b0, 2'd2, 1'b0, 1'b0, 0, 56'd0, 129'd0, 0, 0, 56'h8_0000_5100, 129'd0};
    tv[10] = '{64'hA000_0040, 1'b0, 2'd3, 1'b0, 1'b1, 2, 56'h7_0000_3040, 129'd0, 4, 2, 56'h7_0000_3040, 129'd0};
    tv[11] = '{64'hA000_0048, 1'b0, 2'd3, 1'b0, 1'b0, 1, 56'h7_0000_3048, 129'd0, 0, 1, 56'h7_0000_3048, 129'd0};
    tv[12] = '{64'h8000_1008, 1'b0, 2'd3, 1'b0, 1'b0, 1, 56'h8_0000_5008, 129'd0, 0, 1, 56'h8_0000_5008, 129'd0};
    tv[13] = '{64'h8000_1010, 1'b0, 2'd3, 1'b1, 1'b0, 1, 56'h8_0000_5010, 129'd0, 0, 1, 56'h8_0000_5010, 129'd0};
    tv[14] = '{64'h8000_1018, 1'b0, 2'd3, 1'b0, 1'b0, 0, 56'd0, 129'd0, 0, 0, 56'h8_0000_5018, 129'd0};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset ctl", 192'({req_ready, rsp_valid, mmu_req, mmu_st}), 192'(4'b1000));
    chk("reset data", 192'({rsp_paddr, mmu_va}), 192'(0));
    chk("reset ex", 192'(rsp_ex), 192'(0));
    chk("misaligned_ex", 192'(mis_ex), 192'(0));
    for (int i = 0; i < 15; i++) do_req(i, tv[i]);
    @(negedge clk);
    req_valid = 1'b1; req_va = 64'hB000_0000; req_st = 1'b1; req_sz = 2'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst mmu_req", 192'(mmu_req), 192'(1));
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("rst ctl", 192'({req_ready, rsp_valid, mmu_req, mmu_st}), 192'(4'b1000));
    chk("rst data", 192'({rsp_paddr, mmu_va}), 192'(0));
    chk("rst ex", 192'(rsp_ex), 192'(0));
    mmu_valid = 1'b1; mmu_pa = 56'h1_2345_6000;
    @(posedge clk); #1 mmu_valid = 1'b0;
    chk("late mmu_valid", 192'({req_ready, rsp_valid, mmu_req, rsp_paddr}), 192'({3'b100, 56'd0}));
    do_req(15, '{64'h8000_1008, 1'b0, 2'd3, 1'b0, 1'b0, 1, 56'h8_0000_5008, 129'd0, 0, 1, 56'h8_0000_5008, 129'd0});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ara_xlat_client.md
Name: ara_xlat_client

Overview:
- Ara-side translation client that turns vector load/store address requests into single-outstanding requests on the CVA6 ARA-MMU port (mmu_req / vaddr / is_store → mmu_valid / paddr / exception).
- Checks element alignment locally and holds a one-entry 4 KiB page cache, so consecutive same-page accesses skip the MMU.
- Sits between Ara's VLSU address generator (upstream) and the core's ARA-MMU interface (downstream).

Parameters:
- VLEN, 64, virtual address width (matches riscv::VLEN).
- PLEN, 56, physical address width (matches riscv::PLEN).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- flush_i  in  1  sfence/satp change; invalidates page cache
- req_valid_i  in  1  address request valid
- req_ready_o  out  1  request accepted
- req_vaddr_i  in  VLEN  virtual address
- req_is_store_i  in  1  1 = store, 0 = load
- req_size_i  in  2  log2 element bytes (0..3)
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_paddr_o  out  PLEN  translated address
- rsp_exception_o  out  exception_t  {cause, tval, valid}
- mmu_req_o  out  1  to core ara_mmu_req_i
- mmu_vaddr_o  out  VLEN  to core ara_vaddr_i
- mmu_is_store_o  out  1  to core ara_is_store_i
- mmu_misaligned_ex_o  out  exception_t  to core ara_misaligned_ex_i; constant all-zero, because misalignment is resolved locally
- mmu_valid_i  in  1  from core ara_mmu_valid_o
- mmu_paddr_i  in  PLEN  from core ara_paddr_o
- mmu_exception_i  in  exception_t  from core ara_exception_o

Behaviour:
- Clocking and reset: one clock (clk_i). Reset is synchronous and active-high (rst_i).
- Reset state:
  - FSM in IDLE; cache valid = 0; kill flag = 0.
  - req_ready_o = 1 (IDLE); rsp_valid_o = 0; mmu_req_o = 0.
  - rsp_paddr_o, rsp_exception_o, mmu_vaddr_o, mmu_is_store_o all 0.
- Reset mid-operation: an in-flight MMU request is dropped; a late mmu_valid_i arriving in IDLE is ignored.
- FSM states: IDLE, MMU_WAIT, RESP.
- IDLE:
  - req_ready_o = 1. On req_valid_i, register vaddr, is_store and size. Next state:
  - Misaligned (vaddr & ((1<<size)-1) != 0) → RESP with exception valid = 1, cause = 6 if store else 4, tval = vaddr (zero-extended), paddr = 0.
  - Else cache hit → RESP with paddr = {ppn_q, vaddr[11:0]}, exception = 0.
  - Else → MMU_WAIT.
  - Misalignment takes priority over a hit.
- Cache hit condition: valid_q && tag_q == vaddr[VLEN-1:12] && (st_ok_q || !is_store).
- MMU_WAIT:
  - mmu_req_o = 1; mmu_vaddr_o and mmu_is_store_o held stable from the registered request until mmu_valid_i.
  - On mmu_valid_i: capture mmu_paddr_i and mmu_exception_i into the response registers; next state RESP.
  - mmu_req_o deasserts in the cycle after mmu_valid_i.
- Cache fill (on mmu_valid_i with exception.valid = 0 and kill = 0):
  - tag_q = vaddr[VLEN-1:12]; ppn_q = mmu_paddr_i[PLEN-1:12]; valid_q = 1.
  - st_ok_q = is_store, OR-ed with the old st_ok_q if the tag is unchanged.
  - Faulting translations are never cached.
- RESP: rsp_valid_o = 1, response held stable until rsp_ready_i; on handshake → IDLE. req_ready_o = 0 outside IDLE.
- Latency:
  - Hit or misaligned: accept at T, rsp_valid_o at T+1.
  - Miss: mmu_req_o at T+1; response one cycle after mmu_valid_i.
  - Peak throughput is one request per 2 cycles.
- flush_i:
  - Clears valid_q in the same cycle; flush has priority over a same-cycle fill.
  - Flush while in MMU_WAIT sets kill; kill suppresses that request's fill and clears on leaving MMU_WAIT.
  - A flush coinciding with acceptance in IDLE forces a miss for the accepted request.
- Single outstanding MMU request; no reordering.

Test Plan:
- Load vaddr 0x8000_1008, size 3, cold cache; MMU answers paddr 0x8_0000_5008 after 3 cycles → mmu_req_o high 3 cycles with vaddr held stable; rsp_paddr 0x8_0000_5008; cache filled.
- Load 0x8000_1FF0, size 2, following the above → no mmu_req_o; rsp_valid_o at T+1; paddr 0x8_0000_5FF0.
- Store 0x8000_1010 after load-only fill → miss, MMU consulted; a following store to 0x8000_1020 hits with paddr 0x8_0000_5020.
- Store 0x8000_1002, size 2 → rsp_exception {valid 1, cause 6, tval 0x8000_1002} at T+1; mmu_req_o never asserted.
- MMU returns page fault (cause 13) for 0x9000_0000 → exception forwarded unchanged; a repeat access misses again.
- flush_i pulsed during MMU_WAIT, then rsp_ready_i held low 4 cycles → response stays stable; the next same-page access misses. rst_i during MMU_WAIT → IDLE, outputs zero, late mmu_valid_i ignored.
